// File: rtl/apb_regfile.sv
// apb_regfile: APB slave exposing REG_COUNT read/write registers with
// optional ACCESS-phase wait states and per-register write-commit strobes.
// Optional feature macro: APB_REGFILE_PSTRB_EN adds s_apb_pstrb byte-lane
// write enables; without it every write updates the full word.
module apb_regfile #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_COUNT   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                            s_apb_aclk,
  input  logic                            s_apb_aresetn,
  input  logic [ADDR_WIDTH-1:0]           s_apb_paddr,
  input  logic                            s_apb_psel,
  input  logic                            s_apb_penable,
  input  logic                            s_apb_pwrite,
  input  logic [DATA_WIDTH-1:0]           s_apb_pwdata,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]         s_apb_pstrb,
`endif
  output logic [DATA_WIDTH-1:0]           s_apb_prdata,
  output logic                            s_apb_pready,
  output logic                            s_apb_pslverr,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
  output logic [REG_COUNT-1:0]            reg_wr_pulse
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int unsigned IDXW   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned CMPW   = ADDR_WIDTH + 10;
  localparam int unsigned WCW    = 4;
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [WCW-1:0]          wait_cnt;
  logic [WCW-1:0]          wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDXW-1:0]         idx;
  logic [NBYTES-1:0]       wstrb;
  logic                    valid;
  logic                    ready;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   rdata;

  // Address decode: word index plus alignment/range check.
  assign idx_full = s_apb_paddr >> OFFS;
  assign idx      = IDXW'(idx_full);
  assign valid    = ((s_apb_paddr & OFFS_MASK) == '0) &&
                    (CMPW'(idx_full) < CMPW'(REG_COUNT));

`ifdef APB_REGFILE_PSTRB_EN
  assign wstrb = s_apb_pstrb;
`else
  assign wstrb = '1;
`endif

  // Completion is gated by reset so nothing leaks out while held in reset.
  assign ready  = s_apb_aresetn && (state == ACCESS) && s_apb_psel &&
                  s_apb_penable && (wait_cnt == WCW'(WAIT_STATES));
  assign commit = ready && s_apb_pwrite && valid;

  assign s_apb_pready  = ready;
  assign s_apb_pslverr = ready && !valid;
  assign s_apb_prdata  = rdata;

  // Read mux: only a valid completing read drives data, else zero.
  always_comb begin
    rdata = '0;
    if (ready && !s_apb_pwrite && valid) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        if (idx == IDXW'(i)) rdata = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and wait-counter logic; psel low anywhere aborts to IDLE.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (s_apb_psel && !s_apb_penable) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = s_apb_psel ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (!s_apb_psel) begin
          state_nxt = IDLE;
        end else if (ready) begin
          state_nxt = (s_apb_psel && !s_apb_penable) ? SETUP : IDLE;
        end else begin
          // Saturate so a stalled penable can never wrap past the target.
          wait_cnt_nxt = (wait_cnt == WCW'(WAIT_STATES)) ? wait_cnt : wait_cnt + WCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge s_apb_aclk) begin
    if (!s_apb_aresetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Register storage with byte-lane write and one-cycle commit strobe.
  always_ff @(posedge s_apb_aclk) begin
    if (!s_apb_aresetn) begin
      reg_q        <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        for (int i = 0; i < int'(REG_COUNT); i++) begin
          if (idx == IDXW'(i)) begin
            reg_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < int'(NBYTES); b++) begin
              if (wstrb[b]) reg_q[i*DATA_WIDTH + b*8 +: 8] <= s_apb_pwdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile.sv
// tb_apb_regfile: directed checks of apb_regfile with a zero-wait and a
// three-wait instance sharing one APB bus (separate psel per instance).
// Build with APB_REGFILE_PSTRB_EN defined to also exercise byte strobes.
module tb_apb_regfile;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  paddr;
  logic         psel0, psel3, penable, pwrite;
  logic [31:0]  pwdata;
`ifdef APB_REGFILE_PSTRB_EN
  logic [3:0]   pstrb;
`endif
  logic [31:0]  prdata0, prdata3;
  logic         pready0, pready3, pslverr0, pslverr3;
  logic [127:0] reg_q0, reg_q3;
  logic [3:0]   pulse0, pulse3;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        err;
  int          lat;

  always #5 clk = ~clk;

  apb_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_COUNT(4), .WAIT_STATES(0)) u_dut0 (
    .s_apb_aclk(clk), .s_apb_aresetn(rstn), .s_apb_paddr(paddr),
    .s_apb_psel(psel0), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .s_apb_pstrb(pstrb),
`endif
    .s_apb_prdata(prdata0), .s_apb_pready(pready0), .s_apb_pslverr(pslverr0),
    .reg_q(reg_q0), .reg_wr_pulse(pulse0)
  );

  apb_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_COUNT(4), .WAIT_STATES(3)) u_dut3 (
    .s_apb_aclk(clk), .s_apb_aresetn(rstn), .s_apb_paddr(paddr),
    .s_apb_psel(psel3), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .s_apb_pstrb(pstrb),
`endif
    .s_apb_prdata(prdata3), .s_apb_pready(pready3), .s_apb_pslverr(pslverr3),
    .reg_q(reg_q3), .reg_wr_pulse(pulse3)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer. lat counts penable cycles sampled before pready; the
  // slave registers the setup phase, so lat = 1 + WAIT_STATES. Returns #1
  // after the completing (commit) edge.
  task automatic xfer(input bit d3, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdv, output logic errv, output int latv);
    bit done;
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = data;
`ifdef APB_REGFILE_PSTRB_EN
    pstrb = strb;
`else
    if (strb != 4'hF) $display("note: strobe ignored in full-word build");
`endif
    psel0 = !d3; psel3 = d3; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    latv = 0; done = 1'b0; rdv = '0; errv = 1'b0;
    while (!done && latv < 40) begin
      @(negedge clk);
      if (d3 ? pready3 : pready0) begin
        rdv = d3 ? prdata3 : prdata0;
        errv = d3 ? pslverr3 : pslverr0;
        done = 1'b1;
      end else begin
        latv++;
        @(posedge clk); #1;
      end
    end
    check("xfer_timeout", 128'(done), 128'd1);
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; paddr = '0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0;
`ifdef APB_REGFILE_PSTRB_EN
    pstrb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready",  128'(pready0),  128'd0);
    check("rst_pslverr", 128'(pslverr0), 128'd0);
    check("rst_prdata",  128'(prdata0),  128'd0);
    check("rst_reg_q0",  reg_q0,         128'd0);
    check("rst_pulse0",  128'(pulse0),   128'd0);
    check("rst_reg_q3",  reg_q3,         128'd0);
    rstn = 1'b1;

    // Zero-wait write then read of register 1.
    xfer(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, err, lat);
    check("wr4_lat", 128'(lat), 128'd1);
    check("wr4_err", 128'(err), 128'd0);
    @(negedge clk);
    check("wr4_pulse", 128'(pulse0), 128'b0010);
    check("wr4_reg_q", reg_q0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    @(negedge clk);
    check("wr4_pulse_off", 128'(pulse0), 128'd0);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, rd, err, lat);
    check("rd4_lat",  128'(lat), 128'd1);
    check("rd4_data", 128'(rd),  128'hDEADBEEF);
    check("rd4_err",  128'(err), 128'd0);

    // Three-wait read of register 0 after reset.
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, err, lat);
    check("ws3_rd_lat",  128'(lat), 128'd4);
    check("ws3_rd_data", 128'(rd),  128'd0);
    check("ws3_rd_err",  128'(err), 128'd0);

    // Out-of-range and misaligned writes, out-of-range read.
    xfer(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, rd, err, lat);
    check("wr10_err",  128'(err), 128'd1);
    check("wr10_data", 128'(rd),  128'd0);
    @(negedge clk);
    check("wr10_pulse", 128'(pulse0), 128'd0);
    check("wr10_reg_q", reg_q0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    xfer(1'b0, 1'b1, 32'h2, 32'h87654321, 4'hF, rd, err, lat);
    check("wr2_err", 128'(err), 128'd1);
    @(negedge clk);
    check("wr2_pulse", 128'(pulse0), 128'd0);
    check("wr2_reg_q", reg_q0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, lat);
    check("rd10_err",  128'(err), 128'd1);
    check("rd10_data", 128'(rd),  128'd0);

    // Last register write/read.
    xfer(1'b0, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF, rd, err, lat);
    @(negedge clk);
    check("wrC_pulse", 128'(pulse0), 128'b1000);
    xfer(1'b0, 1'b0, 32'hC, 32'h0, 4'hF, rd, err, lat);
    check("rdC_data", 128'(rd), 128'hCAFEF00D);

    // penable with psel but no setup phase: must be ignored.
    @(posedge clk); #1;
    paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; psel0 = 1'b1; penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noset_pready", 128'(pready0), 128'd0);
    end
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("noset_reg_q", reg_q0, {32'hCAFEF00D, 32'h0, 32'hDEADBEEF, 32'h0});

    // Abort: psel dropped in the second ACCESS cycle of a three-wait write.
    @(posedge clk); #1;
    paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h55AA55AA; psel3 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pready_a1", 128'(pready3), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pready_a2", 128'(pready3), 128'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_pulse",    128'(pulse3), 128'd0);
    check("abort_reg_q",    reg_q3, 128'd0);
    check("abort_wait_cnt", 128'(u_dut3.wait_cnt), 128'd0);
    check("abort_state",    128'(2'(u_dut3.state)), 128'd0);
    xfer(1'b1, 1'b1, 32'h8, 32'h55AA55AA, 4'hF, rd, err, lat);
    check("post_abort_lat", 128'(lat), 128'd4);
    @(negedge clk);
    check("post_abort_pulse", 128'(pulse3), 128'b0100);
    check("post_abort_reg_q", reg_q3, {32'h0, 32'h55AA55AA, 32'h0, 32'h0});

`ifdef APB_REGFILE_PSTRB_EN
    // Byte-lane writes, including an all-zero strobe.
    xfer(1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, rd, err, lat);
    xfer(1'b0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, rd, err, lat);
    @(negedge clk);
    check("strb_pulse", 128'(pulse0), 128'b0001);
    check("strb_reg0",  128'(reg_q0[31:0]), 128'h11BB33DD);
    xfer(1'b0, 1'b1, 32'h0, 32'h00000000, 4'b0000, rd, err, lat);
    @(negedge clk);
    check("strb0_pulse", 128'(pulse0), 128'b0001);
    check("strb0_reg0",  128'(reg_q0[31:0]), 128'h11BB33DD);
`endif

    // Reset asserted in the cycle a write would commit.
    @(posedge clk); #1;
    paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h0BADF00D; psel0 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_pready_pre", 128'(pready0), 128'd1);
    rstn = 1'b0;
    #1;
    check("rstw_pready",  128'(pready0),  128'd0);
    check("rstw_pslverr", 128'(pslverr0), 128'd0);
    check("rstw_prdata",  128'(prdata0),  128'd0);
    @(negedge clk);
    check("rstw_reg_q", reg_q0, 128'd0);
    check("rstw_pulse", 128'(pulse0), 128'd0);
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0; rstn = 1'b1;
    @(negedge clk);
    check("rstw_pulse_after", 128'(pulse0), 128'd0);
    check("rstw_reg_q_after", reg_q0, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
